frame_mem_arbiter: RTL and testbench
====================================

FRAME_MEM_ARBITER -- requirements
Module: frame_mem_arbiter

Interface
REQ-001 Parameter AW, default 17: memory address width in bits.
REQ-002 Parameter DW, default 12: memory data width, packed {red[3:0], green[3:0], blue[3:0]}.
REQ-003 Parameter MEM_LAT, default 2: fixed memory read latency in cycles, from mem_en with mem_we=0 to mem_rdata valid; legal range 1..4.
REQ-004 clk  in  1  clock for all logic; memory runs on the same clock.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 disp_req  in  1  display scan-out read request; one word per asserted cycle.
REQ-007 disp_addr  in  AW  display read address.
REQ-008 disp_rvalid  out  1  display read data valid.
REQ-009 disp_rdata  out  DW  display read data.
REQ-010 w0_valid / w0_ready  in / out  1 / 1  writer 0 handshake; writer 0 is write-only.
REQ-011 w0_addr / w0_data  in  AW / DW  writer 0 address and data.
REQ-012 h_valid / h_ready  in / out  1 / 1  host port handshake; host port is read or write.
REQ-013 h_we / h_addr / h_wdata  in  1 / AW / DW  host write enable, address and write data.
REQ-014 h_rvalid / h_rdata  out  1 / DW  host read data return.
REQ-015 mem_en / mem_we  out  1 / 1  memory access strobe and write enable.
REQ-016 mem_addr / mem_wdata  out  AW / DW  memory address and write data.
REQ-017 mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after the read strobe.
REQ-018 frame_start  in  1  one-cycle pulse at the start of each video frame.
REQ-019 stall_cnt  out  16  number of cycles in the last completed frame in which any writer had valid=1 and ready=0; saturates at 16'hFFFF.

Function
REQ-020 Exactly one memory access per cycle; the arbiter is a combinational grant with registered memory outputs, so mem_* changes 1 cycle after the winning request.
REQ-021 Priority: disp_req has absolute priority; when disp_req=1, w0_ready=0 and h_ready=0.
REQ-022 When disp_req=0, w0 and host arbitrate round-robin; a last_grant register points to the loser of the most recent writer grant; on a tie, last_grant selects the winner.
REQ-023 When only one writer is valid and disp_req=0, that writer is granted in the same cycle regardless of last_grant.
REQ-024 A transfer occurs when valid & ready are both 1; ready depends on valid only through arbitration, and a granted writer completes in that cycle.
REQ-025 Winning-access register: mem_en=1 and mem_addr set from the winning source; mem_we=1 for w0, h_we for the host and 0 for the display; mem_wdata is taken from the winning writer.
REQ-026 An idle cycle (no request) drives mem_en=0, and mem_addr/mem_wdata hold their previous values.
REQ-027 Read-return tag pipeline: MEM_LAT+1 stages of {disp, host} tags; disp_rvalid (or h_rvalid) is asserted exactly MEM_LAT+1 cycles after the accepted request cycle, with rdata = mem_rdata registered in that cycle.
REQ-028 Read data is returned in request order; the display and host returns never overlap in one cycle because the tags are exclusive.
REQ-029 A host write produces no h_rvalid, and a w0 transfer produces no return.
REQ-030 Stall counter: a running 16-bit counter increments by 1 on each stalled cycle (any writer valid & ~ready), saturating at FFFF.
REQ-031 On frame_start, stall_cnt takes the running value (including the current cycle if it stalls) and the running counter clears to 0, or to 1 if the current cycle stalls.
REQ-032 Simultaneous disp_req and a writer request at frame boundaries requires no special handling beyond REQ-021.
REQ-033 Same-address hazard: if a host read follows a w0 write to the same address, it observes the new data because accesses are strictly serialized and the memory is write-first.

Reset
REQ-034 On rst: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, all tag stages cleared, disp_rvalid=0, h_rvalid=0, last_grant selects w0 first, running counter=0, stall_cnt=0.
REQ-035 w0_ready=0 and h_ready=0 while rst=1.
REQ-036 rst asserted mid-operation discards all in-flight reads; no rvalid appears afterwards for requests issued before rst.

Verification
REQ-037 Display read of addr 0x00010 with no other traffic, MEM_LAT=2 -> mem_en/mem_we=1/0 at cycle+1; disp_rvalid=1 with matching data at cycle+3; h_rvalid stays 0.
REQ-038 disp_req, w0_valid and h_valid held high for 10 cycles -> w0_ready=h_ready=0 throughout; on the next frame_start, stall_cnt=10.
REQ-039 w0_valid and h_valid both held high, disp_req=0 -> grants alternate w0, h, w0, h; the first grant after reset goes to w0.
REQ-040 w0 writes 0xABC to addr 5, then host reads addr 5 on the next cycle -> h_rvalid=1 with h_rdata=0xABC, MEM_LAT+1 cycles after the host grant.
REQ-041 Host read issued, then rst pulsed for 1 cycle before the data returns -> no h_rvalid occurs; all outputs at their reset values.
REQ-042 Stall condition held continuously across 70000 cycles, then frame_start -> stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/frame_mem_arbiter_if.sv
// Bus bundle for the frame memory arbiter: display read port, writer 0,
// host port, the single-ported memory side and the per-frame stall counter.
interface frame_mem_arbiter_if #(
  parameter int AW = 17,
  parameter int DW = 12
);
  // Display scan-out read port
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_rvalid;
  logic [DW-1:0] disp_rdata;

  // Writer 0 (write-only)
  logic          w0_valid;
  logic          w0_ready;
  logic [AW-1:0] w0_addr;
  logic [DW-1:0] w0_data;

  // Host port (read or write)
  logic          h_valid;
  logic          h_ready;
  logic          h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic          h_rvalid;
  logic [DW-1:0] h_rdata;

  // Memory side
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Frame timing and contention statistics
  logic          frame_start;
  logic [15:0]   stall_cnt;

  // Arbiter view
  modport slave (
    input  disp_req, disp_addr,
    output disp_rvalid, disp_rdata,
    input  w0_valid, w0_addr, w0_data,
    output w0_ready,
    input  h_valid, h_we, h_addr, h_wdata,
    output h_ready, h_rvalid, h_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    input  frame_start,
    output stall_cnt
  );

  // Requester / memory view
  modport master (
    output disp_req, disp_addr,
    input  disp_rvalid, disp_rdata,
    output w0_valid, w0_addr, w0_data,
    input  w0_ready,
    output h_valid, h_we, h_addr, h_wdata,
    input  h_ready, h_rvalid, h_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    output frame_start,
    input  stall_cnt
  );
endinterface

// File: rtl/frame_mem_arbiter.sv
// frame_mem_arbiter: shares one single-ported frame memory between the
// display scan-out (absolute priority), writer 0 and the host port.
// One access per cycle; the grant is combinational and the memory strobe
// is registered, so the memory sees the winner one cycle later. Read data
// is routed back using a tag pipeline sized to the memory latency, and a
// per-frame stall counter measures writer back-pressure.
// MEM_LAT must lie in 1..4.
module frame_mem_arbiter #(
  parameter int AW      = 17,
  parameter int DW      = 12,
  parameter int MEM_LAT = 2
) (
  input logic                clk,
  input logic                rst,
  frame_mem_arbiter_if.slave bus
);

  // Grant source encoding
  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_DISP = 2'd1;
  localparam logic [1:0] SRC_W0   = 2'd2;
  localparam logic [1:0] SRC_HOST = 2'd3;

  // Round-robin pointer: names the writer that wins the next tie
  localparam logic LG_W0   = 1'b0;
  localparam logic LG_HOST = 1'b1;

  logic [1:0]    grant;
  logic          last_grant;

  logic          mem_en_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;

  logic [MEM_LAT:0] tag_disp_q;
  logic [MEM_LAT:0] tag_host_q;

  logic          stall_now;
  logic [15:0]   run_cnt_q;
  logic [15:0]   run_cnt_inc;
  logic [15:0]   stall_cnt_q;

  // Pick this cycle's winner: display first, then writers round-robin;
  // nothing is granted while in reset so both readies stay low
  always_comb begin
    grant = SRC_NONE;
    if (rst) begin
      grant = SRC_NONE;
    end else if (bus.disp_req) begin
      grant = SRC_DISP;
    end else if (bus.w0_valid && bus.h_valid) begin
      grant = (last_grant == LG_HOST) ? SRC_HOST : SRC_W0;
    end else if (bus.w0_valid) begin
      grant = SRC_W0;
    end else if (bus.h_valid) begin
      grant = SRC_HOST;
    end
  end

  assign bus.w0_ready = (grant == SRC_W0);
  assign bus.h_ready  = (grant == SRC_HOST);

  // After each writer grant, point at the writer that just lost
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= LG_W0;
    end else if (grant == SRC_W0) begin
      last_grant <= LG_HOST;
    end else if (grant == SRC_HOST) begin
      last_grant <= LG_W0;
    end
  end

  // Register the winning access onto the memory port; idle cycles keep
  // address and write data so the memory pins do not toggle needlessly
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_en_q <= (grant != SRC_NONE);
      case (grant)
        SRC_DISP: begin
          mem_we_q   <= 1'b0;
          mem_addr_q <= bus.disp_addr;
        end
        SRC_W0: begin
          mem_we_q    <= 1'b1;
          mem_addr_q  <= bus.w0_addr;
          mem_wdata_q <= bus.w0_data;
        end
        SRC_HOST: begin
          mem_we_q    <= bus.h_we;
          mem_addr_q  <= bus.h_addr;
          mem_wdata_q <= bus.h_wdata;
        end
        default: begin
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  // Shift read-owner tags alongside the memory latency; stage 0 loads with
  // the memory strobe and the last stage lines up with valid mem_rdata
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_disp_q <= '0;
      tag_host_q <= '0;
    end else begin
      tag_disp_q <= {tag_disp_q[MEM_LAT-1:0], (grant == SRC_DISP)};
      tag_host_q <= {tag_host_q[MEM_LAT-1:0], (grant == SRC_HOST) && !bus.h_we};
    end
  end

  assign bus.disp_rvalid = tag_disp_q[MEM_LAT];
  assign bus.h_rvalid    = tag_host_q[MEM_LAT];
  assign bus.disp_rdata  = tag_disp_q[MEM_LAT] ? bus.mem_rdata : '0;
  assign bus.h_rdata     = tag_host_q[MEM_LAT] ? bus.mem_rdata : '0;

  // A writer stalls when it asks but is not the granted source
  assign stall_now = (bus.w0_valid && (grant != SRC_W0)) ||
                     (bus.h_valid  && (grant != SRC_HOST));

  assign run_cnt_inc = (stall_now && (run_cnt_q != 16'hFFFF)) ?
                       run_cnt_q + 16'd1 : run_cnt_q;

  // Count stalled cycles per frame, publishing the total at frame start
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else if (bus.frame_start) begin
      stall_cnt_q <= run_cnt_inc;
      run_cnt_q   <= {15'd0, stall_now};
    end else begin
      run_cnt_q <= run_cnt_inc;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// tb_frame_mem_arbiter: drives the arbiter against a behavioural
// write-first memory and compares every output with a transaction-level
// model (served source per cycle, queue of pending read returns with due
// cycles, shadow memory contents and an integer stall tally).
module tb_frame_mem_arbiter;

  localparam int AW      = 17;
  localparam int DW      = 12;
  localparam int MEM_LAT = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  frame_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  frame_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Memory model: synchronous, write-first, MEM_LAT cycle read latency
  logic [DW-1:0] ram    [0:(1<<AW)-1];
  logic [DW-1:0] rd_pipe[0:MEM_LAT-1];

  assign bus.mem_rdata = rd_pipe[MEM_LAT-1];

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
    rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? ram[bus.mem_addr] : '0;
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // Reference model state
  typedef enum logic [1:0] {WHO_NONE, WHO_DISP, WHO_W0, WHO_HOST} who_t;
  typedef struct {
    int            due;
    bit            disp;
    logic [DW-1:0] data;
  } ret_t;

  logic [DW-1:0] shadow[0:(1<<AW)-1];
  ret_t          retq[$];
  int            cyc        = 0;
  bit            host_turn  = 1'b0;
  int            run_stall  = 0;
  int            snap_stall = 0;
  logic          nxt_en     = 1'b0;
  logic          nxt_we     = 1'b0;
  logic [AW-1:0] nxt_addr   = '0;
  logic [DW-1:0] nxt_wdata  = '0;

  // Expectations for the cycle currently being observed
  logic          exp_w0_ready, exp_h_ready;
  logic          exp_disp_rvalid, exp_h_rvalid;
  logic [DW-1:0] exp_rdata;
  logic          exp_mem_en, exp_mem_we;
  logic [AW-1:0] exp_mem_addr;
  logic [DW-1:0] exp_mem_wdata;
  logic [15:0]   exp_stall_cnt;

  // Evaluate one cycle of the model from the driven inputs, then advance
  // it across the coming clock edge
  task automatic model_eval();
    who_t who;
    bit   stalled;
    ret_t r;
    exp_mem_en      = nxt_en;
    exp_mem_we      = nxt_we;
    exp_mem_addr    = nxt_addr;
    exp_mem_wdata   = nxt_wdata;
    exp_stall_cnt   = 16'(snap_stall);
    exp_disp_rvalid = 1'b0;
    exp_h_rvalid    = 1'b0;
    exp_rdata       = '0;
    if (retq.size() > 0 && retq[0].due == cyc) begin
      r = retq.pop_front();
      if (r.disp) exp_disp_rvalid = 1'b1;
      else        exp_h_rvalid    = 1'b1;
      exp_rdata = r.data;
    end
    who = WHO_NONE;
    if (!rst) begin
      if (bus.disp_req)                    who = WHO_DISP;
      else if (bus.w0_valid && bus.h_valid) who = host_turn ? WHO_HOST : WHO_W0;
      else if (bus.w0_valid)               who = WHO_W0;
      else if (bus.h_valid)                who = WHO_HOST;
    end
    exp_w0_ready = (who == WHO_W0);
    exp_h_ready  = (who == WHO_HOST);
    stalled = (bus.w0_valid && !exp_w0_ready) || (bus.h_valid && !exp_h_ready);
    if (rst) begin
      nxt_en = 1'b0; nxt_we = 1'b0; nxt_addr = '0; nxt_wdata = '0;
      retq.delete();
      host_turn  = 1'b0;
      run_stall  = 0;
      snap_stall = 0;
    end else begin
      nxt_en = (who != WHO_NONE);
      case (who)
        WHO_DISP: begin
          nxt_we   = 1'b0;
          nxt_addr = bus.disp_addr;
          retq.push_back('{due: cyc + MEM_LAT + 1, disp: 1'b1, data: shadow[bus.disp_addr]});
        end
        WHO_W0: begin
          nxt_we = 1'b1; nxt_addr = bus.w0_addr; nxt_wdata = bus.w0_data;
          shadow[bus.w0_addr] = bus.w0_data;
          host_turn = 1'b1;
        end
        WHO_HOST: begin
          nxt_we = bus.h_we; nxt_addr = bus.h_addr; nxt_wdata = bus.h_wdata;
          if (bus.h_we) shadow[bus.h_addr] = bus.h_wdata;
          else retq.push_back('{due: cyc + MEM_LAT + 1, disp: 1'b0, data: shadow[bus.h_addr]});
          host_turn = 1'b0;
        end
        default: nxt_we = 1'b0;
      endcase
      if (bus.frame_start) begin
        snap_stall = (run_stall + int'(stalled) > 65535) ? 65535 : run_stall + int'(stalled);
        run_stall  = int'(stalled);
      end else begin
        run_stall = (run_stall + int'(stalled) > 65535) ? 65535 : run_stall + int'(stalled);
      end
    end
    cyc++;
  endtask

  // Wait for the sampling point of the current cycle and run the model
  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  // Move to the next cycle; inputs are changed just after the edge
  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.disp_req    = 1'b0;
    bus.disp_addr   = '0;
    bus.w0_valid    = 1'b0;
    bus.w0_addr     = '0;
    bus.w0_data     = '0;
    bus.h_valid     = 1'b0;
    bus.h_we        = 1'b0;
    bus.h_addr      = '0;
    bus.h_wdata     = '0;
    bus.frame_start = 1'b0;
  endtask

  task automatic pulse_reset();
    drive_idle();
    rst = 1'b1;
    settle();
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    settle();
    advance();
    bus.disp_req = 1'b1;
    bus.w0_valid = 1'b1;
    bus.h_valid  = 1'b1;
    bus.w0_addr  = AW'($urandom);
    bus.h_addr   = AW'($urandom);
    settle();
    vectors++;
    if (bus.w0_ready !== 1'b0 || bus.h_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ready got w0=%b h=%b want 0/0", bus.w0_ready, bus.h_ready);
    end
    vectors++;
    if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_mem got en=%b we=%b addr=%h wdata=%h want all 0",
               bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    vectors++;
    if (bus.disp_rvalid !== 1'b0 || bus.h_rvalid !== 1'b0 || bus.stall_cnt !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL reset_ret got drv=%b hrv=%b stall=%h want 0/0/0000",
               bus.disp_rvalid, bus.h_rvalid, bus.stall_cnt);
    end
    advance();
    rst = 1'b0;
    drive_idle();
  endtask

  task automatic test_disp_read();
    logic [DW-1:0] want;
    want = shadow[17'h00010];
    bus.disp_req  = 1'b1;
    bus.disp_addr = 17'h00010;
    settle();
    advance();
    drive_idle();
    for (int k = 1; k <= MEM_LAT + 2; k++) begin
      settle();
      if (k == 1) begin
        vectors++;
        if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 17'h00010) begin
          miscompares++;
          $display("[TB] FAIL disp_strobe got en=%b we=%b addr=%h want 1/0/00010",
                   bus.mem_en, bus.mem_we, bus.mem_addr);
        end
      end
      vectors++;
      if (bus.disp_rvalid !== (k == MEM_LAT + 1) || bus.h_rvalid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL disp_rvalid k=%0d got drv=%b hrv=%b want drv=%b hrv=0",
                 k, bus.disp_rvalid, bus.h_rvalid, (k == MEM_LAT + 1));
      end
      if (k == MEM_LAT + 1) begin
        vectors++;
        if (bus.disp_rdata !== want) begin
          miscompares++;
          $display("[TB] FAIL disp_rdata got %h want %h", bus.disp_rdata, want);
        end
      end
      advance();
    end
  endtask

  task automatic test_round_robin();
    pulse_reset();
    bus.w0_valid = 1'b1;
    bus.h_valid  = 1'b1;
    bus.h_we     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.w0_addr = AW'($urandom_range(64, 127));
      bus.w0_data = DW'($urandom);
      bus.h_addr  = AW'($urandom_range(64, 127));
      bus.h_wdata = DW'($urandom);
      settle();
      vectors++;
      if (bus.w0_ready !== (i % 2 == 0) || bus.h_ready !== (i % 2 == 1)) begin
        miscompares++;
        $display("[TB] FAIL rr_grant i=%0d got w0=%b h=%b want w0=%b h=%b",
                 i, bus.w0_ready, bus.h_ready, (i % 2 == 0), (i % 2 == 1));
      end
      advance();
    end
    drive_idle();
  endtask

  task automatic test_raw_hazard();
    bus.w0_valid = 1'b1;
    bus.w0_addr  = 17'd5;
    bus.w0_data  = 12'hABC;
    settle();
    vectors++;
    if (bus.w0_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL raw_w0_ready got %b want 1", bus.w0_ready);
    end
    advance();
    drive_idle();
    bus.h_valid = 1'b1;
    bus.h_we    = 1'b0;
    bus.h_addr  = 17'd5;
    settle();
    vectors++;
    if (bus.h_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL raw_h_ready got %b want 1", bus.h_ready);
    end
    advance();
    drive_idle();
    for (int k = 1; k <= MEM_LAT + 2; k++) begin
      settle();
      vectors++;
      if (bus.h_rvalid !== (k == MEM_LAT + 1)) begin
        miscompares++;
        $display("[TB] FAIL raw_h_rvalid k=%0d got %b want %b", k, bus.h_rvalid, (k == MEM_LAT + 1));
      end
      if (k == MEM_LAT + 1) begin
        vectors++;
        if (bus.h_rdata !== 12'hABC) begin
          miscompares++;
          $display("[TB] FAIL raw_h_rdata got %h want abc", bus.h_rdata);
        end
      end
      advance();
    end
  endtask

  task automatic test_priority_stall();
    bus.frame_start = 1'b1;
    settle();
    advance();
    drive_idle();
    for (int i = 0; i < 10; i++) begin
      bus.disp_req  = 1'b1;
      bus.disp_addr = AW'($urandom);
      bus.w0_valid  = 1'b1;
      bus.w0_addr   = AW'($urandom);
      bus.h_valid   = 1'b1;
      bus.h_we      = 1'($urandom);
      bus.h_addr    = AW'($urandom);
      settle();
      vectors++;
      if (bus.w0_ready !== 1'b0 || bus.h_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL prio_ready i=%0d got w0=%b h=%b want 0/0", i, bus.w0_ready, bus.h_ready);
      end
      advance();
    end
    drive_idle();
    bus.frame_start = 1'b1;
    settle();
    advance();
    drive_idle();
    settle();
    vectors++;
    if (bus.stall_cnt !== 16'd10 || bus.stall_cnt !== exp_stall_cnt) begin
      miscompares++;
      $display("[TB] FAIL prio_stall_cnt got %0d want 10", bus.stall_cnt);
    end
    advance();
  endtask

  task automatic test_reset_flush();
    bus.h_valid = 1'b1;
    bus.h_we    = 1'b0;
    bus.h_addr  = AW'($urandom_range(1, 1000));
    settle();
    vectors++;
    if (bus.h_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL flush_h_ready got %b want 1", bus.h_ready);
    end
    advance();
    pulse_reset();
    for (int k = 0; k <= MEM_LAT + 3; k++) begin
      settle();
      vectors++;
      if (bus.h_rvalid !== 1'b0 || bus.disp_rvalid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL flush_rvalid k=%0d got hrv=%b drv=%b want 0/0", k, bus.h_rvalid, bus.disp_rvalid);
      end
      if (k == 0) begin
        vectors++;
        if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== '0 ||
            bus.mem_wdata !== '0 || bus.stall_cnt !== 16'h0000) begin
          miscompares++;
          $display("[TB] FAIL flush_outputs got en=%b we=%b addr=%h wdata=%h stall=%h want all 0",
                   bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.stall_cnt);
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.disp_req    = ($urandom_range(0, 3) == 0);
      bus.disp_addr   = AW'($urandom_range(0, 15));
      bus.w0_valid    = 1'($urandom);
      bus.w0_addr     = AW'($urandom_range(0, 15));
      bus.w0_data     = DW'($urandom);
      bus.h_valid     = 1'($urandom);
      bus.h_we        = 1'($urandom);
      bus.h_addr      = AW'($urandom_range(0, 15));
      bus.h_wdata     = DW'($urandom);
      bus.frame_start = ($urandom_range(0, 19) == 0);
      settle();
      vectors++;
      if (bus.w0_ready !== exp_w0_ready || bus.h_ready !== exp_h_ready) begin
        miscompares++;
        $display("[TB] FAIL rand_ready cyc=%0d got w0=%b h=%b want w0=%b h=%b",
                 cyc, bus.w0_ready, bus.h_ready, exp_w0_ready, exp_h_ready);
      end
      vectors++;
      if (bus.mem_en !== exp_mem_en || bus.mem_addr !== exp_mem_addr || bus.mem_wdata !== exp_mem_wdata) begin
        miscompares++;
        $display("[TB] FAIL rand_mem cyc=%0d got en=%b addr=%h wdata=%h want en=%b addr=%h wdata=%h",
                 cyc, bus.mem_en, bus.mem_addr, bus.mem_wdata, exp_mem_en, exp_mem_addr, exp_mem_wdata);
      end
      if (exp_mem_en) begin
        vectors++;
        if (bus.mem_we !== exp_mem_we) begin
          miscompares++;
          $display("[TB] FAIL rand_mem_we cyc=%0d got %b want %b", cyc, bus.mem_we, exp_mem_we);
        end
      end
      vectors++;
      if (bus.disp_rvalid !== exp_disp_rvalid || bus.h_rvalid !== exp_h_rvalid) begin
        miscompares++;
        $display("[TB] FAIL rand_rvalid cyc=%0d got drv=%b hrv=%b want drv=%b hrv=%b",
                 cyc, bus.disp_rvalid, bus.h_rvalid, exp_disp_rvalid, exp_h_rvalid);
      end
      if (exp_disp_rvalid) begin
        vectors++;
        if (bus.disp_rdata !== exp_rdata) begin
          miscompares++;
          $display("[TB] FAIL rand_disp_rdata cyc=%0d got %h want %h", cyc, bus.disp_rdata, exp_rdata);
        end
      end
      if (exp_h_rvalid) begin
        vectors++;
        if (bus.h_rdata !== exp_rdata) begin
          miscompares++;
          $display("[TB] FAIL rand_h_rdata cyc=%0d got %h want %h", cyc, bus.h_rdata, exp_rdata);
        end
      end
      vectors++;
      if (bus.stall_cnt !== exp_stall_cnt) begin
        miscompares++;
        $display("[TB] FAIL rand_stall_cnt cyc=%0d got %0d want %0d", cyc, bus.stall_cnt, exp_stall_cnt);
      end
      advance();
    end
    drive_idle();
  endtask

  task automatic test_saturation();
    bus.frame_start = 1'b1;
    settle();
    advance();
    drive_idle();
    bus.disp_req = 1'b1;
    bus.w0_valid = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      settle();
      advance();
    end
    drive_idle();
    bus.frame_start = 1'b1;
    settle();
    advance();
    drive_idle();
    settle();
    vectors++;
    if (bus.stall_cnt !== 16'hFFFF) begin
      miscompares++;
      $display("[TB] FAIL sat_stall_cnt got %h want ffff", bus.stall_cnt);
    end
    advance();
  endtask

  // Test sequence
  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]    = DW'(i * 37 + 11);
      shadow[i] = DW'(i * 37 + 11);
    end
    for (int i = 0; i < MEM_LAT; i++) rd_pipe[i] = '0;
    $display("[TB] starting frame_mem_arbiter bench");
    test_reset();
    test_disp_read();
    test_round_robin();
    test_raw_hazard();
    test_priority_stall();
    test_reset_flush();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
